// File: rtl/my_ifu_pkg.sv
// my_ifu_pkg: shared definitions for the miniLA instruction fetch unit.
//   ifu_state_e   - fetch-unit state encoding (FETCH / VALID / ADEF)
//   INST_NOP_ZERO - word presented in an address-error slot
//   pc_aligned()  - word-alignment test on a fetch address
package my_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_FETCH = 2'd0,
        IFU_VALID = 2'd1,
        IFU_ADEF  = 2'd2
    } ifu_state_e;

    localparam logic [31:0] INST_NOP_ZERO = 32'h0000_0000;

    function automatic logic pc_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/my_ifu.sv
// my_ifu: instruction fetch unit for the miniLA single-cycle core.
// Holds the architectural PC, fetches one word at a time from instruction
// memory over a req/ack handshake and presents it to decode over a
// valid/ready handshake. On accept the PC is loaded from my_NPC; a
// misaligned next PC produces an address-error slot without touching memory.
//
// Ports:
//   cpu_clk, cpu_rst        clock, asynchronous active-high reset
//   npc                     next PC, sampled only on an accept cycle
//   imem_req/imem_addr      fetch request and address (addr always == pc)
//   imem_ack/imem_rdata     memory completion and instruction word
//   pc, inst, adef          slot presented to decode
//   inst_valid/inst_ready   decode handshake
//   inst_cnt                number of accepted slots (wraps)
module my_ifu
    import my_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        adef,
    output logic [31:0] inst_cnt
);

    // A misaligned reset vector starts straight in an address-error slot.
    localparam ifu_state_e RESET_STATE = pc_aligned(RESET_PC) ? IFU_FETCH : IFU_ADEF;

    ifu_state_e  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_cnt_reg, inst_cnt_next;
    // Cleared by reset, set on the first edge after release. Keeps the
    // request (and decode valid) low while reset is asserted and through the
    // remainder of the release cycle, so a stale ack for a request aborted by
    // reset can never be captured.
    logic        started_reg;
    logic        accept;

    assign imem_req   = started_reg && (state_reg == IFU_FETCH);
    assign imem_addr  = pc_reg;
    assign inst_valid = started_reg && (state_reg != IFU_FETCH);
    assign adef       = started_reg && (state_reg == IFU_ADEF);
    assign pc         = pc_reg;
    assign inst       = inst_reg;
    assign inst_cnt   = inst_cnt_reg;

    assign accept = inst_valid && inst_ready;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_reg    <= RESET_STATE;
            pc_reg       <= RESET_PC;
            inst_reg     <= INST_NOP_ZERO;
            inst_cnt_reg <= 32'h0;
            started_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            inst_cnt_reg <= inst_cnt_next;
            started_reg  <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        inst_next     = inst_reg;
        inst_cnt_next = inst_cnt_reg;
        case (state_reg)
            IFU_FETCH: begin
                if (imem_req && imem_ack) begin
                    inst_next  = imem_rdata;
                    state_next = IFU_VALID;
                end
            end
            IFU_VALID, IFU_ADEF: begin
                if (accept) begin
                    pc_next       = npc;
                    inst_cnt_next = inst_cnt_reg + 32'd1;
                    if (pc_aligned(npc)) begin
                        state_next = IFU_FETCH;
                    end else begin
                        // Misaligned target: never issued to memory.
                        inst_next  = INST_NOP_ZERO;
                        state_next = IFU_ADEF;
                    end
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

endmodule

// File: tb/tb_my_ifu.sv
module tb_my_ifu;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } slot_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] npc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        adef;
    logic [31:0] inst_cnt;

    // second instance with a non-zero reset vector for the reset-abort test
    logic        rst2 = 1'b1;
    logic [31:0] npc2 = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        valid2;
    logic        ready2 = 1'b0;
    logic        adef2;
    logic [31:0] cnt2;

    localparam logic [31:0] RPC2 = 32'h1C00_0000;

    int          checks = 0;
    int          errors = 0;
    slot_t       sb[$];
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_cnt = 32'h0;

    always #5 cpu_clk = ~cpu_clk;

    my_ifu #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .adef(adef), .inst_cnt(inst_cnt)
    );

    my_ifu #(.RESET_PC(RPC2)) dut2 (
        .cpu_clk(cpu_clk), .cpu_rst(rst2), .npc(npc2),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .pc(pc2), .inst(inst2), .inst_valid(valid2),
        .inst_ready(ready2), .adef(adef2), .inst_cnt(cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], 16'h5A3C} ^ 32'h0300_0000;
    endfunction

    // Fetch at exp_pc with ack after dly idle request cycles.
    task automatic do_fetch(input int dly, input logic [31:0] rdata);
        check_val("fetch_valid0", inst_valid, 1'b0);
        check_val("fetch_req", imem_req, 1'b1);
        check_val("fetch_addr", imem_addr, exp_pc);
        check_val("fetch_pc", pc, exp_pc);
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0;
            @(posedge cpu_clk);
            @(negedge cpu_clk);
            check_val("wait_req", imem_req, 1'b1);
            check_val("wait_addr", imem_addr, exp_pc);
            check_val("wait_valid0", inst_valid, 1'b0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sb.push_back(slot_t'{exp_pc, rdata, 1'b0});
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        $display("fetch addr=%h delay=%0d word=%h", exp_pc, dly, rdata);
    endtask

    // Check the presented slot, stall, then accept with next pc nxt.
    task automatic accept(input logic [31:0] nxt, input int stall);
        slot_t e;
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_val("slot_valid", inst_valid, 1'b1);
        check_val("slot_pc", pc, e.pc);
        check_val("slot_inst", inst, e.inst);
        check_val("slot_adef", adef, e.adef);
        check_val("slot_req0", imem_req, 1'b0);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0;
            imem_ack   = 1'b1;           // must be ignored outside FETCH
            imem_rdata = 32'hBAD0_0000 + i;
            @(posedge cpu_clk);
            @(negedge cpu_clk);
            check_val("stall_valid", inst_valid, 1'b1);
            check_val("stall_pc", pc, e.pc);
            check_val("stall_inst", inst, e.inst);
            check_val("stall_adef", adef, e.adef);
            check_val("stall_req0", imem_req, 1'b0);
        end
        imem_ack   = 1'b0;
        npc        = nxt;
        inst_ready = 1'b1;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        inst_ready = 1'b0;
        exp_cnt++;
        exp_pc = nxt;
        check_val("acc_cnt", inst_cnt, exp_cnt);
        check_val("acc_pc", pc, nxt);
        if (nxt[1:0] != 2'b00) begin
            sb.push_back(slot_t'{nxt, 32'h0, 1'b1});
        end
        $display("accept pc=%h inst=%h adef=%0d stall=%0d npc=%h cnt=%h",
                 e.pc, e.inst, e.adef, stall, nxt, inst_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_valid", inst_valid, 1'b0);
        check_val("rst_adef", adef, 1'b0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_inst", inst, 32'h0);
        check_val("rst_cnt", inst_cnt, 32'h0);
        check_val("rst2_pc", pc2, RPC2);
        cpu_rst = 1'b0;
        rst2    = 1'b0;
        #1;
        check_val("rel_req0", imem_req, 1'b0);
        @(negedge cpu_clk);

        // ack in the request cycle, first word
        do_fetch(0, 32'h0280_0421);
        accept(32'h0000_0004, 0);
        // delayed ack, stalled decode
        do_fetch(3, mem_word(32'h4));
        accept(32'h0000_0008, 5);
        do_fetch(1, mem_word(32'h8));
        // misaligned targets, back to back
        accept(32'h0000_1002, 0);
        accept(32'h0000_2003, 2);
        accept(32'h0000_2000, 0);
        do_fetch(0, mem_word(32'h2000));
        // counter wrap
        force dut.inst_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.inst_cnt_reg;
        exp_cnt = 32'hFFFF_FFFF;
        accept(32'h0000_2004, 1);
        do_fetch(2, mem_word(32'h2004));
        accept(32'h0000_2008, 0);
        check_val("sb_drained", sb.size(), 32'd0);

        // reset abort on the second instance
        check_val("d2_req", req2, 1'b1);
        check_val("d2_addr", addr2, RPC2);
        ack2   = 1'b1;
        rdata2 = 32'h1111_2222;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        ack2 = 1'b0;
        check_val("d2_valid", valid2, 1'b1);
        check_val("d2_inst", inst2, 32'h1111_2222);
        npc2   = RPC2 + 32'h8;
        ready2 = 1'b1;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        ready2 = 1'b0;
        check_val("d2_cnt", cnt2, 32'd1);
        check_val("d2_addr8", addr2, RPC2 + 32'h8);
        check_val("d2_req8", req2, 1'b1);
        #2;
        rst2 = 1'b1;
        #1;
        check_val("d2_rst_req", req2, 1'b0);
        check_val("d2_rst_pc", pc2, RPC2);
        check_val("d2_rst_valid", valid2, 1'b0);
        check_val("d2_rst_inst", inst2, 32'h0);
        check_val("d2_rst_cnt", cnt2, 32'h0);
        ack2   = 1'b1;
        rdata2 = 32'h3333_4444;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        rst2 = 1'b0;                     // late ack still high after release
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        ack2 = 1'b0;
        check_val("d2_late_valid", valid2, 1'b0);
        check_val("d2_late_inst", inst2, 32'h0);
        check_val("d2_refetch_req", req2, 1'b1);
        check_val("d2_refetch_addr", addr2, RPC2);
        ack2   = 1'b1;
        rdata2 = 32'h5555_6666;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        ack2 = 1'b0;
        check_val("d2_refetch_valid", valid2, 1'b1);
        check_val("d2_refetch_inst", inst2, 32'h5555_6666);
        $display("reset-abort refetch addr=%h word=%h", addr2, inst2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
